// File: rtl/buzzer_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// buzzer_arbiter_pkg
// Shared definitions for the buzzer arbiter: source codes, FSM state codes,
// default tick counts and the duration/gap counter width.
// ---------------------------------------------------------------------------
package buzzer_arbiter_pkg;

  // Width of the shared duration/gap down-counter (longest sound is 60 ticks).
  localparam int CNT_W = 7;

  // Default durations, all in game_en ticks.
  localparam int PAD_TICKS_DEF  = 20;
  localparam int WALL_TICKS_DEF = 10;
  localparam int GOAL_TICKS_DEF = 60;
  localparam int GAP_TICKS_DEF  = 2;
  localparam int GOAL_SEG_DEF   = 4;

  // Sound sources; the encoding is visible on the src output port.
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WALL = 2'd1,
    SRC_PAD  = 2'd2,
    SRC_GOAL = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // Counter load value for a duration of `ticks` ticks (counts down to zero).
  function automatic logic [CNT_W-1:0] ticks_to_load(input int ticks);
    return CNT_W'(ticks - 1);
  endfunction

endpackage

// File: rtl/buzzer_arbiter_tick_downcounter.sv
// ---------------------------------------------------------------------------
// tick_downcounter
// Loadable down-counter with a decrement enable and a zero flag. Load has
// priority over decrement; decrement stops at zero.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         load load_val this cycle
//   load_val     value to load
//   dec          decrement by one (ignored when loading or already zero)
//   count        current value
//   zero         count == 0
// ---------------------------------------------------------------------------
module tick_downcounter #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its inputs, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/buzzer_arbiter.sv
// ---------------------------------------------------------------------------
// buzzer_arbiter
// Shares the piezo buzzer between wall, paddle and goal sounds. One-cycle
// request pulses are latched as pending bits; the highest pending source
// (goal > pad > wall) plays for a fixed number of game_en ticks, followed by
// a short silent gap when another sound is waiting. A goal request preempts
// anything else and drops the interrupted/waiting pad and wall sounds. A
// request for the sound already playing restarts its duration. pause freezes
// timing and mutes the output; requests are still latched.
//
// Optional feature: define BUZZ_GOAL_MELODY_EN to make the goal sound
// alternate pad_tone / wall_tone every GOAL_SEG ticks (starting with
// pad_tone). Without it the goal sound is a steady pad_tone.
//
// Ports:
//   clk, rst_n   pixel clock, asynchronous active-low reset
//   game_en      one-cycle duration tick (~210 Hz)
//   pause        level, freezes state/counters and mutes the buzzer
//   wall_hit     request pulse, wall sound
//   pad_hit      request pulse, paddle sound
//   goal         request pulse, goal sound
//   pad_tone     low-pitch square wave
//   wall_tone    high-pitch square wave
//   buzzer       registered piezo drive
//   busy         high while playing or in the inter-sound gap
//   src          source now playing (0 none, 1 wall, 2 pad, 3 goal)
// ---------------------------------------------------------------------------
module buzzer_arbiter
  import buzzer_arbiter_pkg::*;
#(
  parameter int PAD_TICKS  = PAD_TICKS_DEF,
  parameter int WALL_TICKS = WALL_TICKS_DEF,
  parameter int GOAL_TICKS = GOAL_TICKS_DEF,
  parameter int GAP_TICKS  = GAP_TICKS_DEF,
  parameter int GOAL_SEG   = GOAL_SEG_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_en,
  input  logic       pause,
  input  logic       wall_hit,
  input  logic       pad_hit,
  input  logic       goal,
  input  logic       pad_tone,
  input  logic       wall_tone,
  output logic       buzzer,
  output logic       busy,
  output logic [1:0] src
);

  state_e           state_q, state_d;
  src_e             src_q, src_d;
  logic [3:1]       pend_q, pend_d;
  logic [3:1]       req, req_eff, pend_clr, retrig_mask;
  logic             retrig, preempt, tick;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_val, cnt_unused;
  logic             seg_rst;
  logic             goal_tone, tone_sel;

  function automatic logic [CNT_W-1:0] load_for(input src_e s);
    unique case (s)
      SRC_WALL: return ticks_to_load(WALL_TICKS);
      SRC_PAD:  return ticks_to_load(PAD_TICKS);
      SRC_GOAL: return ticks_to_load(GOAL_TICKS);
      default:  return '0;
    endcase
  endfunction

  assign req  = {goal, pad_hit, wall_hit};
  assign tick = game_en & ~pause;

  tick_downcounter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .count    (cnt_unused),
    .zero     (cnt_zero)
  );

  // NOTE: every signal written below gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    pend_clr    = '0;
    cnt_load    = 1'b0;
    cnt_val     = '0;
    cnt_dec     = 1'b0;
    seg_rst     = 1'b0;
    retrig_mask = '0;

    // A request for the sound currently playing restarts it (even while paused).
    if (state_q == ST_PLAY) begin
      unique case (src_q)
        SRC_WALL: retrig_mask[1] = wall_hit;
        SRC_PAD:  retrig_mask[2] = pad_hit;
        SRC_GOAL: retrig_mask[3] = goal;
        default:  retrig_mask    = '0;
      endcase
    end
    retrig = |retrig_mask;

    // A goal (new or latched during pause) takes over unless goal already plays.
    preempt = (goal | pend_q[3]) & ~pause & ~((state_q == ST_PLAY) && (src_q == SRC_GOAL));

    req_eff = req & ~retrig_mask;

    if (preempt) begin
      state_d  = ST_PLAY;
      src_d    = SRC_GOAL;
      cnt_load = 1'b1;
      cnt_val  = load_for(SRC_GOAL);
      pend_clr = '1;
      req_eff  = '0;
      seg_rst  = 1'b1;
    end else if (retrig) begin
      cnt_load = 1'b1;
      cnt_val  = load_for(src_q);
      seg_rst  = (src_q == SRC_GOAL);
    end else if (!pause) begin
      unique case (state_q)
        ST_IDLE: begin
          // Selection looks only at already-latched bits; same-cycle requests
          // wait for the next round.
          if (pend_q[2]) begin
            state_d     = ST_PLAY;
            src_d       = SRC_PAD;
            pend_clr[2] = 1'b1;
            cnt_load    = 1'b1;
            cnt_val     = load_for(SRC_PAD);
          end else if (pend_q[1]) begin
            state_d     = ST_PLAY;
            src_d       = SRC_WALL;
            pend_clr[1] = 1'b1;
            cnt_load    = 1'b1;
            cnt_val     = load_for(SRC_WALL);
          end
        end
        ST_PLAY: begin
          if (tick) begin
            if (!cnt_zero) begin
              cnt_dec = 1'b1;
            end else if ((pend_q | req_eff) != '0) begin
              state_d  = ST_GAP;
              src_d    = SRC_NONE;
              cnt_load = 1'b1;
              cnt_val  = ticks_to_load(GAP_TICKS);
            end else begin
              state_d = ST_IDLE;
              src_d   = SRC_NONE;
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            if (!cnt_zero) cnt_dec = 1'b1;
            else           state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    pend_d = (pend_q & ~pend_clr) | req_eff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= SRC_NONE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      pend_q  <= pend_d;
    end
  end

`ifdef BUZZ_GOAL_MELODY_EN
  logic [CNT_W-1:0] seg_q;
  logic             phase_q;

  // Counts goal ticks within a segment; phase 0 plays pad_tone, 1 wall_tone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= '0;
      phase_q <= 1'b0;
    end else if (seg_rst) begin
      seg_q   <= '0;
      phase_q <= 1'b0;
    end else if ((state_q == ST_PLAY) && (src_q == SRC_GOAL) && tick) begin
      if (seg_q == CNT_W'(GOAL_SEG - 1)) begin
        seg_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        seg_q <= seg_q + 1'b1;
      end
    end
  end

  assign goal_tone = phase_q ? wall_tone : pad_tone;
`else
  logic seg_rst_unused;
  assign seg_rst_unused = seg_rst;
  assign goal_tone      = pad_tone;
`endif

  always_comb begin
    tone_sel = 1'b0;
    unique case (src_q)
      SRC_WALL: tone_sel = wall_tone;
      SRC_PAD:  tone_sel = pad_tone;
      SRC_GOAL: tone_sel = goal_tone;
      default:  tone_sel = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) buzzer <= 1'b0;
    else        buzzer <= (state_q == ST_PLAY) && !pause && tone_sel;
  end

  assign busy = (state_q != ST_IDLE);
  assign src  = src_q;

endmodule
